mode_dispatch_unit: RTL and testbench



---
 rtl/dispatch_pkg.sv | 29 ++
 rtl/dispatch_stats_counter.sv | 24 ++
 rtl/mode_dispatch_unit.sv | 144 ++++++++++++++
 tb/tb_mode_dispatch_unit.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/dispatch_pkg.sv
// rtl/dispatch_pkg.sv - shared types and constants for the mode dispatch stage
//
// Contents:
//   dispatchState_e : dispatch FSM states (IDLE, SEND, DRAIN)
//   OPT_*           : op_type encodings
//   MODE_*          : execution mode encodings
//   targetOf()      : pipe selection for a decoded instruction
package dispatch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEND  = 2'd1,
        DRAIN = 2'd2
    } dispatchState_e;

    localparam logic [1:0] OPT_ARITH_REG = 2'b00;
    localparam logic [1:0] OPT_ARITH_IMM = 2'b01;
    localparam logic [1:0] OPT_MEM       = 2'b10;
    localparam logic [1:0] OPT_CTRL      = 2'b11;

    localparam logic MODE_SCALAR = 1'b0;
    localparam logic MODE_VECTOR = 1'b1;

    // Control instructions always execute on the scalar pipe.
    function automatic logic targetOf(input logic [1:0] opType, input logic mode);
        return (opType == OPT_CTRL) ? MODE_SCALAR : mode;
    endfunction

endpackage

// File: rtl/dispatch_stats_counter.sv
// rtl/dispatch_stats_counter.sv - saturating event counter with enable
//
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   en       : count this cycle
//   count    : current value, sticks at all-ones
module dispatch_stats_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (en && (count != '1)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/mode_dispatch_unit.sv
// rtl/mode_dispatch_unit.sv - one-entry dispatch buffer with mode/control ordering barriers
//
// Optional feature macro: DISPATCH_STATS_EN (adds STAT_W, sc_count, vc_count, stall_count).
//
// Ports:
//   clk, rst                  : clock, asynchronous active-high reset
//   in_valid/in_ready         : upstream instruction handshake
//   in_op_type/op_code/mode   : decoded instruction fields, in_instr payload
//   sc_valid/sc_ready         : scalar pipe handshake
//   vc_valid/vc_ready         : vector pipe handshake
//   out_instr/out_op_code     : buffered instruction shared by both pipes
//   sc_busy/vc_busy           : pipe has work in flight
//   cur_mode                  : mode of the last issued instruction
//   sc_count/vc_count/stall_count : issue and drain statistics (macro only)
module mode_dispatch_unit
    import dispatch_pkg::*;
#(
    parameter int INSTR_W = 32
`ifdef DISPATCH_STATS_EN
    , parameter int STAT_W = 16
`endif
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [1:0]         in_op_type,
    input  logic [3:0]         in_op_code,
    input  logic               in_mode,
    input  logic [INSTR_W-1:0] in_instr,
    output logic               sc_valid,
    input  logic               sc_ready,
    output logic               vc_valid,
    input  logic               vc_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [3:0]         out_op_code,
    input  logic               sc_busy,
    input  logic               vc_busy,
    output logic               cur_mode
`ifdef DISPATCH_STATS_EN
    , output logic [STAT_W-1:0] sc_count
    , output logic [STAT_W-1:0] vc_count
    , output logic [STAT_W-1:0] stall_count
`endif
);

    dispatchState_e state;
    logic           bufTarget;
    logic           bufCtrl;

    logic issueHs;
    logic accept;
    logic inTarget;
    logic inCtrl;
    logic effMode;
    logic needDrain;
    logic barrierOk;

    assign issueHs  = (state == SEND) && (bufTarget ? vc_ready : sc_ready);
    assign in_ready = (state == IDLE) || issueHs;
    assign accept   = in_valid && in_ready;

    assign sc_valid = (state == SEND) && (bufTarget == MODE_SCALAR);
    assign vc_valid = (state == SEND) && (bufTarget == MODE_VECTOR);

    assign inTarget = targetOf(in_op_type, in_mode);
    assign inCtrl   = (in_op_type == OPT_CTRL);

    // A same-cycle reload must see the mode of the instruction issuing now.
    assign effMode   = issueHs ? bufTarget : cur_mode;
    assign needDrain = inCtrl || (inTarget != effMode);

    // While draining, cur_mode still names the pipe that ran the older work.
    always_comb begin
        barrierOk = 1'b0;
        if (bufCtrl) begin
            barrierOk = !sc_busy && !vc_busy;
        end else if (cur_mode == MODE_SCALAR) begin
            barrierOk = !sc_busy;
        end else begin
            barrierOk = !vc_busy;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            out_instr   <= '0;
            out_op_code <= '0;
            bufTarget   <= MODE_SCALAR;
            bufCtrl     <= 1'b0;
            cur_mode    <= MODE_SCALAR;
        end else begin
            if (issueHs) begin
                cur_mode <= bufTarget;
            end
            if (accept) begin
                out_instr   <= in_instr;
                out_op_code <= in_op_code;
                bufTarget   <= inTarget;
                bufCtrl     <= inCtrl;
                state       <= needDrain ? DRAIN : SEND;
            end else begin
                case (state)
                    SEND: begin
                        if (issueHs) begin
                            state <= IDLE;
                        end
                    end
                    DRAIN: begin
                        if (barrierOk) begin
                            state <= SEND;
                        end
                    end
                    default: state <= state;
                endcase
            end
        end
    end

`ifdef DISPATCH_STATS_EN
    dispatch_stats_counter #(.W(STAT_W)) uScCount (
        .clk   (clk),
        .rst   (rst),
        .en    (issueHs && (bufTarget == MODE_SCALAR)),
        .count (sc_count)
    );

    dispatch_stats_counter #(.W(STAT_W)) uVcCount (
        .clk   (clk),
        .rst   (rst),
        .en    (issueHs && (bufTarget == MODE_VECTOR)),
        .count (vc_count)
    );

    dispatch_stats_counter #(.W(STAT_W)) uStallCount (
        .clk   (clk),
        .rst   (rst),
        .en    (state == DRAIN),
        .count (stall_count)
    );
`endif

endmodule

// File: tb/tb_mode_dispatch_unit.sv
// tb/tb_mode_dispatch_unit.sv - scoreboard bench for mode_dispatch_unit
module tb_mode_dispatch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_op_type;
    logic [3:0]  in_op_code;
    logic        in_mode;
    logic [31:0] in_instr;
    logic        sc_valid, sc_ready;
    logic        vc_valid, vc_ready;
    logic [31:0] out_instr;
    logic [3:0]  out_op_code;
    logic        sc_busy, vc_busy;
    logic        cur_mode;
`ifdef DISPATCH_STATS_EN
    logic [15:0] sc_count, vc_count, stall_count;
`endif

    mode_dispatch_unit dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_op_type  (in_op_type),
        .in_op_code  (in_op_code),
        .in_mode     (in_mode),
        .in_instr    (in_instr),
        .sc_valid    (sc_valid),
        .sc_ready    (sc_ready),
        .vc_valid    (vc_valid),
        .vc_ready    (vc_ready),
        .out_instr   (out_instr),
        .out_op_code (out_op_code),
        .sc_busy     (sc_busy),
        .vc_busy     (vc_busy),
        .cur_mode    (cur_mode)
`ifdef DISPATCH_STATS_EN
        , .sc_count    (sc_count)
        , .vc_count    (vc_count)
        , .stall_count (stall_count)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        vec;
        logic [3:0]  code;
        logic [31:0] instr;
        int          cyc;
    } exp_t;

    exp_t sb[$];

    task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    task automatic push(input logic vec, input logic [3:0] code, input logic [31:0] instr,
                        input int c);
        exp_t e;
        e.vec = vec; e.code = code; e.instr = instr; e.cyc = c;
        sb.push_back(e);
    endtask

    // Present one instruction; returns the cycle it was accepted and how many
    // cycles in_ready was low first.
    task automatic drive(input logic [1:0] t, input logic [3:0] c, input logic m,
                         input logic [31:0] d, output int acc, output int waits);
        in_valid = 1'b1; in_op_type = t; in_op_code = c; in_mode = m; in_instr = d;
        waits = 0;
        @(negedge clk);
        while (!in_ready && waits < 50) begin
            @(negedge clk);
            waits++;
        end
        if (!in_ready) check("accept_timeout", 64'(in_ready), 64'd1);
        acc = cyc;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: every issue handshake is matched against the queue.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst) begin
            if (sc_valid && vc_valid) check("both_valid", 64'd1, 64'd0);
            if ((sc_valid && sc_ready) || (vc_valid && vc_ready)) begin
                if (sb.size() == 0) begin
                    check("unexpected_issue", 64'(cyc), 64'hFFFF_FFFF);
                end else begin
                    e = sb.pop_front();
                    check("issue_pipe",  64'(vc_valid),    64'(e.vec));
                    check("issue_instr", 64'(out_instr),   64'(e.instr));
                    check("issue_code",  64'(out_op_code), 64'(e.code));
                    check("issue_cycle", 64'(cyc),         64'(e.cyc));
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int a, a0, w;
        rst = 1'b1; in_valid = 1'b0; in_op_type = 2'b00; in_op_code = 4'h0;
        in_mode = 1'b0; in_instr = 32'h0; sc_ready = 1'b1; vc_ready = 1'b1;
        sc_busy = 1'b0; vc_busy = 1'b0;
        #3;
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_sc_valid", 64'(sc_valid), 64'd0);
        check("rst_vc_valid", 64'(vc_valid), 64'd0);
        check("rst_out_instr", 64'(out_instr), 64'd0);
        check("rst_cur_mode", 64'(cur_mode), 64'd0);
        @(negedge clk); rst = 1'b0;
        idle(2);

        // Three back-to-back scalar arith.
        for (int i = 0; i < 3; i++) begin
            drive(2'b00, 4'(i + 1), 1'b0, 32'hA000_0000 + 32'(i), a, w);
            check("b2b_no_wait", 64'(w), 64'd0);
            push(1'b0, 4'(i + 1), 32'hA000_0000 + 32'(i), a + 1);
        end
        idle(2);
`ifdef DISPATCH_STATS_EN
        check("b2b_stall", 64'(stall_count), 64'd0);
`endif

        // Mode change to vector while scalar pipe busy.
        sc_busy = 1'b1;
        drive(2'b00, 4'h5, 1'b1, 32'hB000_0005, a, w);
        push(1'b1, 4'h5, 32'hB000_0005, a + 5);
        idle(3);
        sc_busy = 1'b0;
        idle(3);
        check("mode_cur_vec", 64'(cur_mode), 64'd1);
`ifdef DISPATCH_STATS_EN
        check("mode_stall", 64'(stall_count), 64'd4);
`endif

        // Vector backpressure.
        vc_ready = 1'b0;
        drive(2'b10, 4'h6, 1'b1, 32'hC000_0006, a, w);
        push(1'b1, 4'h6, 32'hC000_0006, a + 4);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_vc_valid", 64'(vc_valid), 64'd1);
            check("bp_instr", 64'(out_instr), 64'hC000_0006);
            check("bp_code", 64'(out_op_code), 64'h6);
            check("bp_in_ready", 64'(in_ready), 64'd0);
            @(posedge clk); #1;
        end
        vc_ready = 1'b1;
        idle(2);
`ifdef DISPATCH_STATS_EN
        check("bp_vc_count", 64'(vc_count), 64'd2);
`endif

        // Control instruction with vector mode bit goes scalar after full drain.
        vc_busy = 1'b1;
        drive(2'b11, 4'h7, 1'b1, 32'hD000_0007, a, w);
        push(1'b0, 4'h7, 32'hD000_0007, a + 3);
        @(negedge clk);
        check("ctrl_drain_sc", 64'(sc_valid), 64'd0);
        check("ctrl_drain_vc", 64'(vc_valid), 64'd0);
        @(posedge clk); #1;
        vc_busy = 1'b0;
        idle(3);
        check("ctrl_cur_mode", 64'(cur_mode), 64'd0);

        // Mode switch accepted in the same cycle as an issue handshake.
        drive(2'b01, 4'h8, 1'b0, 32'hE000_0008, a0, w);
        push(1'b0, 4'h8, 32'hE000_0008, a0 + 1);
        drive(2'b10, 4'h9, 1'b1, 32'hE000_0009, a, w);
        check("swap_no_wait", 64'(w), 64'd0);
        push(1'b1, 4'h9, 32'hE000_0009, a0 + 3);
        drive(2'b00, 4'hA, 1'b1, 32'hE000_000A, a, w);
        check("swap_wait", 64'(w), 64'd1);
        push(1'b1, 4'hA, 32'hE000_000A, a0 + 4);
        idle(3);
`ifdef DISPATCH_STATS_EN
        check("sum_sc", 64'(sc_count), 64'd5);
        check("sum_vc", 64'(vc_count), 64'd4);
        check("sum_stall", 64'(stall_count), 64'd7);
`endif

        // Reset while draining.
        vc_busy = 1'b1;
        drive(2'b00, 4'hB, 1'b0, 32'hF000_000B, a, w);
        rst = 1'b1;
        #1;
        check("mid_in_ready", 64'(in_ready), 64'd1);
        check("mid_sc_valid", 64'(sc_valid), 64'd0);
        check("mid_vc_valid", 64'(vc_valid), 64'd0);
        check("mid_cur_mode", 64'(cur_mode), 64'd0);
        check("mid_out_instr", 64'(out_instr), 64'd0);
`ifdef DISPATCH_STATS_EN
        check("mid_counts", 64'({sc_count, vc_count, stall_count}), 64'd0);
`endif
        @(negedge clk); rst = 1'b0; vc_busy = 1'b0;
        idle(4);
        drive(2'b00, 4'hC, 1'b0, 32'h1234_5678, a, w);
        check("post_rst_no_wait", 64'(w), 64'd0);
        push(1'b0, 4'hC, 32'h1234_5678, a + 1);
        idle(4);
        check("sb_empty", 64'(sb.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
